// File: rtl/window_apply.sv
// Window-function multiplier: fetches samples and coefficients from the address
// manager, forms the rounded and saturated product, and streams it out with a frame marker.
module window_apply #(
   parameter int unsigned ADDRWIDTH = 12,
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned COEFWIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 empty,
   input  logic                 read,
   input  logic                 last_in,
   output logic                 dequeue,
   input  logic [DATAWIDTH-1:0] ram_rdata,
   input  logic [COEFWIDTH-1:0] coef_rdata,
   output logic [DATAWIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic [15:0]          frame_count
);

   localparam int unsigned PW    = DATAWIDTH + COEFWIDTH + 1;
   localparam int unsigned DEPTH = 4;
   localparam logic signed [PW-1:0] RND_BIAS = PW'(1) << (COEFWIDTH - 1);
   localparam logic signed [PW-1:0] SAT_MAX  = (PW'(1) << (DATAWIDTH - 1)) - PW'(1);
   localparam logic signed [PW-1:0] SAT_MIN  = ~SAT_MAX;

   if (ADDRWIDTH < 1 || DATAWIDTH < 2 || COEFWIDTH < 1) begin : g_param_check
      $error("window_apply: invalid parameter set");
   end

   logic                        s0_valid_q, s0_last_q;
   logic                        s1_valid_q, s1_last_q;
   logic        [DATAWIDTH-1:0] s1_data_q;
   logic        [COEFWIDTH-1:0] s1_coef_q;
   logic                        s2_valid_q, s2_last_q;
   logic signed [PW-1:0]        s2_prod_q;

   logic signed [PW-1:0]        a_ext, b_ext, prod_d, sum_d, rnd_d;
   logic        [DATAWIDTH-1:0] result_d;

   logic        [DATAWIDTH-1:0] buf_data_q [DEPTH];
   logic                        buf_last_q [DEPTH];
   logic        [1:0]           rd_ptr_q, wr_ptr_q;
   logic        [2:0]           count_q, count_d;
   logic        [2:0]           inflight_q, inflight_d;
   logic        [15:0]          frame_count_q;
   logic                        push, pop;

   assign out_valid   = (count_q != 3'd0);
   assign pop         = out_valid && out_ready;
   assign push        = s2_valid_q;
   assign out_data    = out_valid ? buf_data_q[rd_ptr_q] : '0;
   assign out_last    = out_valid && buf_last_q[rd_ptr_q];
   assign frame_count = frame_count_q;

   // Credits cover the head entry too, so a sample holds a credit for five cycles
   // and the sustained fetch rate is four samples per five cycles.
   assign dequeue = reset_n && enable && !empty &&
                    (({1'b0, inflight_q} + {1'b0, count_q}) < 4'd4);

   always_comb begin
      a_ext      = {{(COEFWIDTH + 1){s1_data_q[DATAWIDTH-1]}}, s1_data_q};
      b_ext      = {{(DATAWIDTH + 1){1'b0}}, s1_coef_q};
      prod_d     = a_ext * b_ext;
      sum_d      = s2_prod_q + RND_BIAS;
      rnd_d      = sum_d >>> COEFWIDTH;
      if (rnd_d > SAT_MAX) begin
         result_d = SAT_MAX[DATAWIDTH-1:0];
      end else if (rnd_d < SAT_MIN) begin
         result_d = SAT_MIN[DATAWIDTH-1:0];
      end else begin
         result_d = rnd_d[DATAWIDTH-1:0];
      end
      inflight_d = inflight_q + {2'b00, read} - {2'b00, push};
      count_d    = count_q + {2'b00, push} - {2'b00, pop};
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         s0_valid_q    <= 1'b0;
         s0_last_q     <= 1'b0;
         s1_valid_q    <= 1'b0;
         s1_last_q     <= 1'b0;
         s1_data_q     <= '0;
         s1_coef_q     <= '0;
         s2_valid_q    <= 1'b0;
         s2_last_q     <= 1'b0;
         s2_prod_q     <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         inflight_q    <= '0;
         frame_count_q <= '0;
      end else begin
         // RAM/ROM data lag read by one cycle, so the tag waits in s0 for it
         s0_valid_q    <= read;
         s0_last_q     <= read && last_in;
         s1_valid_q    <= s0_valid_q;
         s1_last_q     <= s0_last_q;
         s1_data_q     <= ram_rdata;
         s1_coef_q     <= coef_rdata;
         s2_valid_q    <= s1_valid_q;
         s2_last_q     <= s1_last_q;
         s2_prod_q     <= prod_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 2'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 2'd1;
         end
         if (pop && out_last) begin
            frame_count_q <= frame_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         buf_data_q[wr_ptr_q] <= result_d;
         buf_last_q[wr_ptr_q] <= s2_last_q;
      end
   end

endmodule

// File: tb/tb_window_apply.sv
// Scoreboard bench for window_apply: a driver emulates the address manager and
// window memories, a monitor checks every presented output against a reference model.
module tb_window_apply;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 16;

   typedef struct {
      logic [DW-1:0] s;
      logic [CW-1:0] c;
      logic          l;
   } src_t;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      int unsigned   cyc;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic          empty = 1'b1;
   logic          read;
   logic          last_in = 1'b0;
   logic          dequeue;
   logic [DW-1:0] ram_rdata = '0;
   logic [CW-1:0] coef_rdata = '0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic [15:0]   frame_count;

   src_t          src_q[$];
   exp_t          sb[$];
   int unsigned   checks = 0;
   int unsigned   errors = 0;
   int unsigned   cyc = 0;
   int unsigned   nreads = 0;
   int unsigned   exp_frames = 0;
   logic          lat_mode = 1'b0;
   logic          track_credit = 1'b0;
   logic          rand_ready = 1'b0;
   logic          rand_empty = 1'b0;
   logic          hold_empty = 1'b0;
   logic          last_deq = 1'b0;

   // The address manager grants a fetch whenever dequeue is raised while not empty
   assign read = dequeue;

   window_apply #(
      .ADDRWIDTH(AW),
      .DATAWIDTH(DW),
      .COEFWIDTH(CW)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .enable(enable),
      .empty(empty),
      .read(read),
      .last_in(last_in),
      .dequeue(dequeue),
      .ram_rdata(ram_rdata),
      .coef_rdata(coef_rdata),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last(out_last),
      .frame_count(frame_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endfunction

   // Rounded product: floor(sample*coef/2^CW + 1/2), clipped to the signed sample range
   function automatic logic [DW-1:0] ref_model(logic [DW-1:0] s, logic [CW-1:0] c);
      longint p;
      longint r;
      longint hi;
      longint lo;
      p  = longint'($signed(s)) * longint'(c);
      r  = (p + (longint'(1) << (CW - 1))) >>> CW;
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -(longint'(1) << (DW - 1));
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      return DW'(r);
   endfunction

   task automatic step();
      src_t it;
      logic got;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      if (rand_empty) hold_empty = ($urandom_range(0, 3) == 0);
      @(negedge clock);
      empty   = (src_q.size() == 0) || hold_empty;
      last_in = (src_q.size() != 0) ? src_q[0].l : 1'b0;
      #2;
      last_deq = dequeue;
      got = 1'b0;
      if (read === 1'b1) begin
         if (src_q.size() == 0) begin
            chk("read_while_empty", {31'd0, read}, 32'd0);
         end else begin
            it  = src_q.pop_front();
            got = 1'b1;
            sb.push_back('{d: ref_model(it.s, it.c), l: it.l, cyc: cyc});
            nreads++;
         end
      end
      @(posedge clock);
      #1;
      if (got) begin
         ram_rdata  = it.s;
         coef_rdata = it.c;
      end else begin
         ram_rdata  = DW'($urandom);
         coef_rdata = CW'($urandom);
      end
   endtask

   task automatic do_reset();
      src_q.delete();
      rand_ready   = 1'b0;
      rand_empty   = 1'b0;
      hold_empty   = 1'b0;
      lat_mode     = 1'b0;
      track_credit = 1'b0;
      reset_n      = 1'b0;
      step();
      reset_n      = 1'b1;
   endtask

   task automatic drain(int unsigned budget);
      int unsigned n;
      n = 0;
      while ((src_q.size() != 0 || sb.size() != 0) && n < budget) begin
         step();
         n++;
      end
      chk("drain_complete", src_q.size() + sb.size(), 32'd0);
   endtask

   // Monitor: compares the buffer head every cycle it is valid, pops on handshake
   initial begin
      forever begin
         @(negedge clock);
         #3;
         if (!reset_n) begin
            sb.delete();
            exp_frames = 0;
         end else begin
            chk("frame_count", {16'd0, frame_count}, exp_frames);
            if (track_credit) chk("credit_limit", {31'd0, sb.size() <= 4}, 32'd1);
            if (out_valid === 1'b1 && sb.size() == 0) begin
               chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else if (out_valid === 1'b1) begin
               chk("out_data", {16'd0, out_data}, {16'd0, sb[0].d});
               chk("out_last", {31'd0, out_last}, {31'd0, sb[0].l});
               if (out_ready) begin
                  if (lat_mode) chk("latency", cyc - sb[0].cyc, 32'd4);
                  if (sb[0].l) exp_frames++;
                  void'(sb.pop_front());
               end
            end else begin
               chk("out_valid_known", {31'd0, out_valid}, 32'd0);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned snap;
      int unsigned n;
      logic [DW-1:0] av [4];
      logic [CW-1:0] ac [4];

      // Reset and idle with the manager empty
      reset_n = 1'b0;
      repeat (3) step();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, out_data}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_dequeue", {31'd0, dequeue}, 32'd0);
      reset_n = 1'b1;
      enable  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_dequeue", {31'd0, dequeue}, 32'd0);
         chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
         chk("idle_frame_count", {16'd0, frame_count}, 32'd0);
      end

      // Arithmetic corner pairs, each expected four cycles after its read
      av[0] = 16'h4000; ac[0] = 16'h8000;
      av[1] = 16'h8000; ac[1] = 16'hFFFF;
      av[2] = 16'h7FFF; ac[2] = 16'hFFFF;
      av[3] = 16'hFFFF; ac[3] = 16'h8000;
      chk("model_0", {16'd0, ref_model(av[0], ac[0])}, 32'h2000);
      chk("model_1", {16'd0, ref_model(av[1], ac[1])}, 32'h8001);
      chk("model_2", {16'd0, ref_model(av[2], ac[2])}, 32'h7FFF);
      chk("model_3", {16'd0, ref_model(av[3], ac[3])}, 32'h0000);
      for (int i = 0; i < 4; i++) src_q.push_back('{s: av[i], c: ac[i], l: 1'b0});
      out_ready = 1'b1;
      lat_mode  = 1'b1;
      drain(60);
      lat_mode  = 1'b0;

      // Full 16-sample window: ramp data, unity-ish coefficient
      do_reset();
      for (int i = 0; i < (1 << AW); i++)
         src_q.push_back('{s: DW'(i), c: 16'hFFFF, l: (i == (1 << AW) - 1)});
      out_ready = 1'b1;
      lat_mode  = 1'b1;
      drain(100);
      lat_mode  = 1'b0;
      step();
      chk("window_frames", {16'd0, frame_count}, 32'd1);

      // Hard backpressure: four fetches then stall, head held
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++)
         src_q.push_back('{s: DW'($urandom), c: CW'($urandom), l: (i == 5)});
      snap = nreads;
      repeat (30) step();
      chk("bp_reads", nreads - snap, 32'd4);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      step();
      chk("bp_dequeue_held", {31'd0, last_deq}, 32'd0);
      step();
      chk("bp_dequeue_reassert", {31'd0, last_deq}, 32'd1);
      drain(200);
      step();
      chk("bp_frames", {16'd0, frame_count}, 32'd1);

      // Random backpressure and gaps over three windows
      do_reset();
      for (int w = 0; w < 3; w++)
         for (int i = 0; i < (1 << AW); i++)
            src_q.push_back('{s: DW'($urandom), c: CW'($urandom), l: (i == (1 << AW) - 1)});
      rand_ready   = 1'b1;
      rand_empty   = 1'b1;
      track_credit = 1'b1;
      drain(3000);
      rand_ready   = 1'b0;
      rand_empty   = 1'b0;
      hold_empty   = 1'b0;
      track_credit = 1'b0;
      chk("random_frames", {16'd0, frame_count}, 32'd3);

      // Reset with one sample buffered and three in flight
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++)
         src_q.push_back('{s: DW'($urandom), c: CW'($urandom), l: (i == 1 || i == 7)});
      snap = nreads;
      n = 0;
      while (nreads - snap < 4 && n < 20) begin
         step();
         n++;
      end
      chk("mid_reads", nreads - snap, 32'd4);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_frame_count", {16'd0, frame_count}, 32'd0);
      out_ready = 1'b1;
      drain(100);
      step();
      chk("mid_frames_after", {16'd0, frame_count}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
